// File: rtl/kv_pkg.sv
// kv_pkg: types and constants shared by the KV cache read-side blocks.
//   kv_pair_t     : one {K,V} element pair as delivered by kv_cache.
//   kv_entry_t    : skid FIFO entry, a pair plus its end-of-command marker.
//   kv_rd_state_e : reader sequencer states.
package kv_pkg;

  // Element width of kv_cache; the reader's DATA_WIDTH must equal this.
  localparam int KV_DATA_WIDTH = 16;

  // kv_cache read data is valid this many cycles after rd_en.
  localparam int KV_RD_LATENCY = 1;

  // Beats that may be outstanding (buffered plus in flight from the cache).
  localparam int KV_OCC_MAX = 2;

  typedef struct packed {
    logic [KV_DATA_WIDTH-1:0] k;
    logic [KV_DATA_WIDTH-1:0] v;
  } kv_pair_t;

  typedef struct packed {
    kv_pair_t pair;
    logic     last;
  } kv_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } kv_rd_state_e;

endpackage

// File: rtl/kv_skid_fifo.sv
// kv_skid_fifo: 2-entry registered FIFO of {kv_pair_t, last}.
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_k/v/last   : write port (caller guarantees no push while full
//                           unless a pop happens in the same cycle)
//   pop_valid, pop_ready  : read-side handshake; pop_k/v/last show the head
//   count                 : current occupancy, 0..2
// The head is read straight out of the storage registers, so payload is
// stable for as long as it is not popped.
module kv_skid_fifo
  import kv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [KV_DATA_WIDTH-1:0] push_k,
  input  logic [KV_DATA_WIDTH-1:0] push_v,
  input  logic                     push_last,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [KV_DATA_WIDTH-1:0] pop_k,
  output logic [KV_DATA_WIDTH-1:0] pop_v,
  output logic                     pop_last,
  output logic [1:0]               count
);

  kv_entry_t r_mem [2];
  logic      r_wr_ptr;
  logic      r_rd_ptr;
  logic [1:0] r_count;

  logic      w_pop;
  kv_entry_t w_push_entry;
  kv_entry_t w_head;

  assign w_pop        = pop_valid & pop_ready;
  assign w_push_entry = '{pair: '{k: push_k, v: push_v}, last: push_last};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= '0;
        end else if (push && (r_wr_ptr == 1'(gi))) begin
          r_mem[gi] <= w_push_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign pop_valid = (r_count != 2'd0);
  assign pop_k     = w_head.pair.k;
  assign pop_v     = w_head.pair.v;
  assign pop_last  = w_head.last;
  assign count     = r_count;

endmodule

// File: rtl/kv_cache_reader.sv
// kv_cache_reader: read-side sequencer for kv_cache.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, base_addr, length   : command (sampled in IDLE only)
//   busy, done                 : command status; done is a one-cycle pulse
//   mem_rd_en, mem_rd_addr     : kv_cache read port
//   mem_k_data, mem_v_data     : kv_cache read data, one cycle after rd_en
//   out_valid/ready/k/v/last   : {K,V} output stream, last on final beat
// Reads are issued only when the 2-entry skid FIFO is guaranteed to have
// room for the returning data, so cache data never needs to be stalled.
module kv_cache_reader
  import kv_pkg::*;
#(
  parameter int DATA_WIDTH = KV_DATA_WIDTH,
  parameter int DEPTH      = 256,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_k_data,
  input  logic [DATA_WIDTH-1:0] mem_v_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_k,
  output logic [DATA_WIDTH-1:0] out_v,
  output logic                  out_last
);

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  kv_rd_state_e r_state;
  kv_rd_state_e w_next_state;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_inflight;       // a read was issued last cycle
  logic              r_inflight_last;  // ...and it was the command's final one

  logic [1:0] w_fifo_count;
  logic [1:0] w_occ;
  logic       w_pop;
  logic       w_credit_ok;
  logic       w_start_ok;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_pop      = out_valid & out_ready;
  assign w_occ      = w_fifo_count + {1'b0, r_inflight};
  // A full FIFO+pipeline can still take a read if a beat leaves this cycle.
  assign w_credit_ok = (w_occ < 2'(KV_OCC_MAX)) ||
                       ((w_occ == 2'(KV_OCC_MAX)) && w_pop);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        // A zero-length command passes through DRAIN with nothing
        // outstanding so that busy is seen for one cycle before done.
        if (start) w_next_state = (length != '0) ? ISSUE : DRAIN;
      end
      ISSUE: begin
        if (mem_rd_en && (r_remaining == REM_ONE)) w_next_state = DRAIN;
      end
      DRAIN: begin
        if ((w_pop && out_last) || ((w_fifo_count == 2'd0) && !r_inflight))
          w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    case (r_state)
      ISSUE: begin
        busy      = 1'b1;
        mem_rd_en = (r_remaining != '0) && w_credit_ok;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Address / remaining counters and the one-deep read pipeline tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_addr      <= base_addr;
        r_remaining <= length;
      end else if (mem_rd_en) begin
        r_addr      <= r_addr + 1'b1;  // natural wrap modulo DEPTH
        r_remaining <= r_remaining - REM_ONE;
      end
      r_inflight      <= mem_rd_en;
      r_inflight_last <= mem_rd_en && (r_remaining == REM_ONE);
    end
  end

  assign mem_rd_addr = r_addr;

  kv_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_inflight),
    .push_k    (mem_k_data),
    .push_v    (mem_v_data),
    .push_last (r_inflight_last),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_k     (out_k),
    .pop_v     (out_v),
    .pop_last  (out_last),
    .count     (w_fifo_count)
  );

endmodule
